if_fetch_stage: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency req/ready instruction-memory port.
- Presents {IF_PC, IF_inst, if_valid} to IF/ID and honours stall from the hazard unit and redirect from branch resolution.
- When no instruction is available, presents a bubble (IF_inst = NOP) so IF/ID can always load.

---
 rtl/if_fetch_stage_pkg.sv | 23 ++
 rtl/if_fetch_stage_pc_reg.sv | 30 +++
 rtl/if_fetch_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   state_e          : fetch FSM encoding (FETCH / HOLD / DRAIN)
//   NOP_INST_DEFAULT : bubble instruction presented when nothing is valid
//   RESET_PC_DEFAULT : first fetch address after reset
//   PC_INC           : sequential PC step (one 32-bit word)
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // request outstanding, response passes straight through
        ST_HOLD  = 2'd1,  // response captured while IF/ID stalled, no request
        ST_DRAIN = 2'd2   // waiting out a response killed by a redirect
    } state_e;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Word-align a redirect address.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// 32-bit address register with synchronous reset and load enable.
// Ports:
//   clk_i       : rising-edge clock
//   rst_i       : synchronous active-high reset, loads RESET_VAL
//   load_en_i   : 1 = capture load_data_i this edge
//   load_data_i : value to load
//   q_o         : current register value
module pc_reg #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_en_i,
    input  logic [31:0] load_data_i,
    output logic [31:0] q_o
);

    logic [31:0] val_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q <= RESET_VAL;
        end else if (load_en_i) begin
            val_q <= load_data_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, drives a variable-latency req/ready instruction memory and
// presents {IF_PC, IF_inst, if_valid} to IF/ID, honouring stall and redirect.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   id_stall             : IF/ID not accepting this cycle
//   br_taken, br_target  : redirect request and address (low 2 bits ignored)
//   imem_req, imem_addr  : fetch request, held with stable address until ready
//   imem_ready, imem_rdata : single-cycle response strobe and data
//   IF_PC, IF_inst, if_valid : presented instruction (NOP_INST when invalid)
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_inst,
    output logic        if_valid
);

    state_e      state_q, state_d;
    logic [31:0] fa_q, fa_d;
    logic [31:0] pc_q, pc_d;
    logic        fa_load, pc_load;
    logic [31:0] hold_inst_q, hold_pc_q;
    logic        hold_load;
    logic [31:0] fa_inc;
    logic [31:0] target;

    assign fa_inc = fa_q + PC_INC;
    assign target = align_word(br_target);

    // Outstanding fetch address (drives imem_addr).
    pc_reg #(.RESET_VAL(RESET_PC)) u_fa_reg (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_en_i   (fa_load),
        .load_data_i (fa_d),
        .q_o         (fa_q)
    );

    // Next fetch address.
    pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_en_i   (pc_load),
        .load_data_i (pc_d),
        .q_o         (pc_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            hold_inst_q <= NOP_INST;
            hold_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (hold_load) begin
                hold_inst_q <= imem_rdata;
                hold_pc_q   <= fa_q;
            end
        end
    end

    assign imem_addr = fa_q;

    always_comb begin
        state_d   = state_q;
        fa_load   = 1'b0;
        fa_d      = fa_q;
        pc_load   = 1'b0;
        pc_d      = pc_q;
        hold_load = 1'b0;
        imem_req  = 1'b0;
        if_valid  = 1'b0;
        IF_inst   = NOP_INST;
        IF_PC     = '0;

        if (!rst) begin
            imem_req = (state_q != ST_HOLD);
            IF_PC    = fa_q;

            unique case (state_q)
                ST_FETCH: begin
                    if (br_taken) begin
                        pc_load = 1'b1;
                        pc_d    = target;
                        if (imem_ready) begin
                            // Response arrives with the redirect: drop it and
                            // start the new stream immediately.
                            fa_load = 1'b1;
                            fa_d    = target;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else if (imem_ready) begin
                        if_valid = 1'b1;
                        IF_inst  = imem_rdata;
                        IF_PC    = fa_q;
                        pc_load  = 1'b1;
                        pc_d     = fa_inc;
                        if (!id_stall) begin
                            fa_load = 1'b1;
                            fa_d    = fa_inc;
                        end else begin
                            hold_load = 1'b1;
                            state_d   = ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    IF_PC = hold_pc_q;
                    if (br_taken) begin
                        pc_load = 1'b1;
                        pc_d    = target;
                        fa_load = 1'b1;
                        fa_d    = target;
                        state_d = ST_FETCH;
                    end else begin
                        if_valid = 1'b1;
                        IF_inst  = hold_inst_q;
                        if (!id_stall) begin
                            fa_load = 1'b1;
                            fa_d    = pc_q;
                            state_d = ST_FETCH;
                        end
                    end
                end

                ST_DRAIN: begin
                    // The stale response is never presented; the newest
                    // redirect target becomes the next fetch address.
                    if (br_taken) begin
                        pc_load = 1'b1;
                        pc_d    = target;
                    end
                    if (imem_ready) begin
                        fa_load = 1'b1;
                        fa_d    = br_taken ? target : pc_q;
                        state_d = ST_FETCH;
                    end
                end

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

endmodule
